// File: rtl/lsu_bus_bridge.sv
// Load/store bridge: turns a memory-stage access into one handshaked bus
// transaction with byte-lane steering, load extension and a response timeout.
module lsu_bus_bridge #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              stall,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              bus_req_valid,
   input  logic              bus_req_ready,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [31:0]       bus_wdata,
   output logic [3:0]        bus_be,
   input  logic              bus_rsp_valid,
   input  logic [31:0]       bus_rsp_data,
   input  logic              bus_rsp_err
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

   localparam int                CNT_W  = $clog2(TIMEOUT + 2);
   localparam logic [CNT_W-1:0]  TO_VAL = CNT_W'(TIMEOUT);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
   logic [2:0]          f3_q, f3_d;
   logic [1:0]          lane_q, lane_d;
   logic                wr_q, wr_d;
   logic                bus_req_valid_q, bus_req_valid_d;
   logic                bus_we_q, bus_we_d;
   logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
   logic [31:0]         bus_wdata_q, bus_wdata_d;
   logic [3:0]          bus_be_q, bus_be_d;
   logic                resp_valid_q, resp_valid_d;
   logic                resp_err_q, resp_err_d;
   logic [31:0]         resp_rdata_q, resp_rdata_d;

   function automatic logic access_legal(input logic wr, input logic [2:0] f3,
                                         input logic [1:0] lane);
      logic ok;
      case (f3)
         3'b000:  ok = 1'b1;
         3'b100:  ok = !wr;
         3'b001:  ok = !lane[0];
         3'b101:  ok = !wr && !lane[0];
         3'b010:  ok = (lane == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] lane);
      logic [3:0] be;
      case (f3[1:0])
         2'b00:   be = 4'b0001 << lane;
         2'b01:   be = 4'b0011 << lane;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] d;
      case (f3[1:0])
         2'b00:   d = {4{wd[7:0]}};
         2'b01:   d = {2{wd[15:0]}};
         default: d = wd;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] word);
      logic [31:0] sh;
      logic [31:0] r;
      sh = word >> {lane, 3'b000};
      case (f3)
         3'b000:  r = {{24{sh[7]}}, sh[7:0]};
         3'b100:  r = {24'd0, sh[7:0]};
         3'b001:  r = {{16{sh[15]}}, sh[15:0]};
         3'b101:  r = {16'd0, sh[15:0]};
         default: r = word;
      endcase
      return r;
   endfunction

   assign cnt_inc = cnt_q + CNT_W'(1);

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      f3_d            = f3_q;
      lane_d          = lane_q;
      wr_d            = wr_q;
      bus_req_valid_d = 1'b0;
      bus_we_d        = 1'b0;
      bus_addr_d      = '0;
      bus_wdata_d     = '0;
      bus_be_d        = '0;
      resp_valid_d    = 1'b0;
      resp_err_d      = 1'b0;
      resp_rdata_d    = '0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               f3_d   = req_funct3;
               lane_d = req_addr[1:0];
               wr_d   = req_write;
               if (access_legal(req_write, req_funct3, req_addr[1:0])) begin
                  state_d         = ADDR;
                  bus_req_valid_d = 1'b1;
                  bus_we_d        = req_write;
                  bus_addr_d      = {req_addr[ADDR_W-1:2], 2'b00};
                  bus_wdata_d     = lane_wdata(req_funct3, req_wdata);
                  bus_be_d        = lane_be(req_funct3, req_addr[1:0]);
               end else begin
                  // Illegal access: answer with an error, never touch the bus.
                  state_d      = DONE;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end
            end
         end
         ADDR: begin
            if (bus_req_ready) begin
               state_d = DATA;
               cnt_d   = '0;
            end else begin
               bus_req_valid_d = bus_req_valid_q;
               bus_we_d        = bus_we_q;
               bus_addr_d      = bus_addr_q;
               bus_wdata_d     = bus_wdata_q;
               bus_be_d        = bus_be_q;
            end
         end
         DATA: begin
            if (bus_rsp_valid) begin
               state_d      = DONE;
               resp_valid_d = 1'b1;
               resp_err_d   = bus_rsp_err;
               if (!bus_rsp_err && !wr_q)
                  resp_rdata_d = load_extend(f3_q, lane_q, bus_rsp_data);
            end else if (TIMEOUT != 0 && cnt_inc == TO_VAL) begin
               state_d      = DONE;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         bus_req_valid_q <= 1'b0;
         bus_we_q        <= 1'b0;
         bus_addr_q      <= '0;
         bus_wdata_q     <= '0;
         bus_be_q        <= '0;
         resp_valid_q    <= 1'b0;
         resp_err_q      <= 1'b0;
         resp_rdata_q    <= '0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         bus_req_valid_q <= bus_req_valid_d;
         bus_we_q        <= bus_we_d;
         bus_addr_q      <= bus_addr_d;
         bus_wdata_q     <= bus_wdata_d;
         bus_be_q        <= bus_be_d;
         resp_valid_q    <= resp_valid_d;
         resp_err_q      <= resp_err_d;
         resp_rdata_q    <= resp_rdata_d;
      end
   end

   // Captured request attributes only matter while an access is in flight.
   always_ff @(posedge clk) begin
      f3_q   <= f3_d;
      lane_q <= lane_d;
      wr_q   <= wr_d;
   end

   assign stall         = req_valid && (state_q != DONE);
   assign resp_valid    = resp_valid_q;
   assign resp_err      = resp_err_q;
   assign resp_rdata    = resp_rdata_q;
   assign bus_req_valid = bus_req_valid_q;
   assign bus_we        = bus_we_q;
   assign bus_addr      = bus_addr_q;
   assign bus_wdata     = bus_wdata_q;
   assign bus_be        = bus_be_q;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Bench for lsu_bus_bridge: directed scenarios plus random accesses, each
// checked cycle by cycle against a transaction-level reference model.
module tb_lsu_bus_bridge;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        stall, resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        bus_req_valid, bus_req_ready, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_rsp_valid, bus_rsp_err;
   logic [31:0] bus_rsp_data;

   int vectors = 0;
   int miscompares = 0;

   lsu_bus_bridge #(.ADDR_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
      .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data), .bus_rsp_err(bus_rsp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, ".stall"}, 32'(stall), 32'd0);
      chk({tag, ".resp_valid"}, 32'(resp_valid), 32'd0);
      chk({tag, ".resp_err"}, 32'(resp_err), 32'd0);
      chk({tag, ".resp_rdata"}, resp_rdata, 32'd0);
      chk({tag, ".bus_req_valid"}, 32'(bus_req_valid), 32'd0);
      chk({tag, ".bus_we"}, 32'(bus_we), 32'd0);
      chk({tag, ".bus_addr"}, bus_addr, 32'd0);
      chk({tag, ".bus_wdata"}, bus_wdata, 32'd0);
      chk({tag, ".bus_be"}, 32'(bus_be), 32'd0);
   endtask

   // Reference rules, expressed as access sizes and byte positions.
   function automatic int acc_size(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit legal(input logic wr, input logic [2:0] f3, input logic [31:0] addr);
      if (f3[1:0] == 2'b11 || f3 == 3'b110) return 0;
      if (wr && f3[2]) return 0;
      return (addr % acc_size(f3)) == 0;
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
      logic [3:0] be = '0;
      int lane = int'(addr % 4);
      for (int i = 0; i < 4; i++)
         be[i] = (i >= lane) && (i < lane + acc_size(f3));
      return be;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] r = '0;
      for (int i = 0; i < 4; i++)
         r[8*i +: 8] = wd[8*(i % acc_size(f3)) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] w);
      int lane = int'(addr % 4);
      int b = int'((w >> (8 * lane)) & 32'hFF);
      int h = int'((w >> (8 * lane)) & 32'hFFFF);
      case (f3)
         3'b000:  return 32'(b >= 128 ? b - 256 : b);
         3'b100:  return 32'(b);
         3'b001:  return 32'(h >= 32768 ? h - 65536 : h);
         3'b101:  return 32'(h);
         default: return w;
      endcase
   endfunction

   // One complete access: rd = cycles of ready delay, sd = cycles in DATA before
   // the response (sd >= TO means the bus never answers in time).
   task automatic run_access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input int rd, input int sd,
                             input logic [31:0] rdat, input logic rerr, input bit stray);
      bit lg = legal(wr, f3, addr);
      bit tmo = lg && (sd >= TO);
      int resp_cyc;
      bit exp_err;
      logic [31:0] exp_rd;
      bit in_addr;
      if (!lg) resp_cyc = 1;
      else if (tmo) resp_cyc = 2 + rd + TO;
      else resp_cyc = 3 + rd + sd;
      exp_err = !lg || tmo || (rerr == 1'b1);
      exp_rd = (exp_err || wr) ? 32'd0 : model_load(f3, addr, rdat);
      for (int c = 0; c <= resp_cyc; c++) begin
         req_valid  = 1'b1;
         req_write  = wr;
         req_funct3 = f3;
         req_addr   = addr;
         req_wdata  = wd;
         bus_req_ready = lg && (c == 1 + rd);
         if (lg && !tmo && c == 2 + rd + sd) begin
            bus_rsp_valid = 1'b1;
            bus_rsp_data  = rdat;
            bus_rsp_err   = rerr;
         end else begin
            bus_rsp_valid = lg && stray && (c >= 1) && (c <= 1 + rd);
            bus_rsp_data  = $urandom;
            bus_rsp_err   = 1'($urandom);
         end
         @(negedge clk);
         in_addr = lg && (c >= 1) && (c <= 1 + rd);
         chk("stall", 32'(stall), 32'(c != resp_cyc));
         chk("resp_valid", 32'(resp_valid), 32'(c == resp_cyc));
         chk("bus_req_valid", 32'(bus_req_valid), 32'(in_addr));
         chk("bus_we", 32'(bus_we), in_addr ? 32'(wr) : 32'd0);
         chk("bus_addr", bus_addr, in_addr ? (addr & ~32'd3) : 32'd0);
         chk("bus_be", 32'(bus_be), in_addr ? 32'(model_be(f3, addr)) : 32'd0);
         chk("bus_wdata", bus_wdata, in_addr ? model_wdata(f3, wd) : 32'd0);
         if (c == resp_cyc) begin
            chk("resp_err", 32'(resp_err), 32'(exp_err));
            chk("resp_rdata", resp_rdata, exp_rd);
         end
         cyc();
      end
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("idle.stall", 32'(stall), 32'd0);
         chk("idle.resp_valid", 32'(resp_valid), 32'd0);
         chk("idle.bus_req_valid", 32'(bus_req_valid), 32'd0);
         cyc();
      end
   endtask

   initial begin
      rst = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
      req_addr = '0; req_wdata = '0;
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_data = '0; bus_rsp_err = 1'b0;
      cyc();
      cyc();
      @(negedge clk);
      chk_quiet("reset0");
      rst = 1'b1;
      cyc();

      // Reset in the middle of DATA, then a stale response that must be ignored.
      req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
      cyc();
      bus_req_ready = 1'b1;
      cyc();
      bus_req_ready = 1'b0;
      cyc();
      rst = 1'b0; req_valid = 1'b0;
      cyc();
      @(negedge clk);
      chk_quiet("rst_mid");
      cyc();
      rst = 1'b1; bus_rsp_valid = 1'b1; bus_rsp_data = 32'hDEADBEEF;
      @(negedge clk);
      chk_quiet("rst_after");
      cyc();
      bus_rsp_valid = 1'b0;
      @(negedge clk);
      chk_quiet("stale_rsp");
      cyc();

      run_access(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80AABBCC, 1'b0, 0);
      idle(1);
      run_access(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 4, 0, 32'h55555555, 1'b0, 1);
      idle(1);
      run_access(1'b0, 3'b010, 32'h06, 32'h0, 0, 0, 32'h0, 1'b0, 0);
      run_access(1'b0, 3'b101, 32'h11, 32'h0, 0, 0, 32'h0, 1'b0, 0);
      idle(1);
      run_access(1'b0, 3'b101, 32'h2, 32'h0, 0, 1, 32'hF00D1234, 1'b0, 0);
      run_access(1'b0, 3'b000, 32'h5, 32'h0, 1, 0, 32'h00007F00, 1'b0, 0);
      idle(1);
      run_access(1'b0, 3'b010, 32'h40, 32'h0, 0, 100, 32'h0, 1'b0, 0);
      run_access(1'b0, 3'b010, 32'h44, 32'h0, 0, 2, 32'hCAFEF00D, 1'b1, 0);
      run_access(1'b1, 3'b000, 32'h47, 32'hA5, 2, 7, 32'h0, 1'b0, 1);
      idle(2);

      for (int n = 0; n < 150; n++) begin
         logic [31:0] a;
         logic [2:0]  f;
         a = {20'd0, 12'($urandom)};
         f = 3'($urandom);
         if ($urandom_range(0, 2) != 0) f = (f[2] ? 3'b100 : 3'b000) | 3'($urandom_range(0, 2));
         run_access(1'($urandom), f, a, $urandom, $urandom_range(0, 3),
                    $urandom_range(0, 10), $urandom, 1'($urandom_range(0, 7) == 0),
                    1'($urandom));
         idle($urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lsu_bus_bridge.md
Name: lsu_bus_bridge

Overview:
- Load/store unit on the data side of the CPU; replaces the single-cycle data-memory access with a handshaked, multi-cycle memory bus.
- Takes the memory-stage request (address = ALU result, store data, funct3, write enable) and performs byte-lane steering plus sign/zero extension.
- Issues one bus transaction per access and returns the load result.
- Holds `stall` high so the pipeline freezes until the access completes.

Parameters:
- ADDR_W, 32, byte-address width.
- TIMEOUT, 255, maximum wait cycles for a bus response; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  1  memory-stage access present; held stable while stall=1.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign field.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- stall  out  1  pipeline hold.
- resp_valid  out  1  one-cycle pulse: access finished.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: misaligned, illegal funct3, bus error or timeout.
- bus_req_valid  out  1  bus request.
- bus_req_ready  in  1  bus accepts the request.
- bus_we  out  1  write strobe.
- bus_addr  out  ADDR_W  word-aligned address; bits [1:0] = 0.
- bus_wdata  out  32  lane-replicated store data.
- bus_be  out  4  byte enables.
- bus_rsp_valid  in  1  response or write acknowledge.
- bus_rsp_data  in  32  read word.
- bus_rsp_err  in  1  bus fault, valid with bus_rsp_valid.

Behaviour:
- Reset (rst=0 at an edge, any state): state goes to IDLE and the timeout counter clears.
  - All outputs are 0: stall, resp_valid, resp_rdata, resp_err, bus_req_valid, bus_we, bus_addr, bus_wdata, bus_be.
  - Any in-flight bus transaction is abandoned; a bus_rsp_valid seen in IDLE is ignored.
- States and transitions:
  - IDLE: on req_valid, capture request fields. If the request is legal, go to ADDR; otherwise go to DONE with err set.
  - ADDR: bus_req_valid=1 with registered bus_addr, bus_we, bus_wdata and bus_be held stable. On bus_req_ready go to DATA and clear the counter.
  - DATA: on bus_rsp_valid, latch the result and err=bus_rsp_err, then go to DONE. Otherwise increment the counter; when TIMEOUT≠0 and counter==TIMEOUT, go to DONE with err=1.
  - DONE: resp_valid=1 for exactly one cycle, then go to IDLE. A req_valid seen in the following IDLE cycle is a new access.
- stall is combinational: stall = req_valid & (state≠DONE). It is low in the DONE cycle so the pipeline advances.
- Minimum latency, zero-wait bus: request seen in cycle N; bus_req_valid in N+1 (ready in N+1); rsp in N+2; resp_valid in N+3. stall is high in N..N+2.
- Legal accesses:
  - funct3 000/100 (byte, store or load): any alignment.
  - funct3 001/101 (half): requires addr[0]=0.
  - funct3 010 (word): requires addr[1:0]=0.
  - Stores allow only 000/001/010.
  - All other cases go to DONE with err=1 one cycle after acceptance (resp_valid at N+1) with no bus activity.
- Byte enables:
  - byte: be = 0001 << addr[1:0].
  - half: be = 0011 << addr[1:0].
  - word: be = 1111.
- bus_wdata replication:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- Loads: select the lane by addr[1:0].
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: pass the word unchanged.
- Stores complete on the write acknowledge (bus_rsp_valid); resp_rdata=0.
- On any error, resp_rdata=0.
- Outputs other than stall are registered. bus_* outputs return to 0 outside ADDR.
- A bus_rsp_valid arriving in ADDR (before the handshake) is ignored.

Test Plan:
- Reset with rst=0 for 2 cycles in mid-DATA, then rst=1 -> all outputs 0, state IDLE; a stale bus_rsp_valid one cycle later produces no resp_valid.
- LB, addr 0x103, zero-wait bus, rsp_data 0x80AABBCC -> bus_addr 0x100, be 1000, resp_rdata 0xFFFFFF80, resp_valid at N+3, stall high exactly 3 cycles.
- SH, addr 0x202, wdata 0x1234ABCD, ready delayed 4 cycles -> bus_req_valid held 5 cycles with be 1100 and wdata 0xABCDABCD; resp_rdata 0, resp_err 0.
- LW at 0x06 and LHU at 0x11 -> resp_err=1 at N+1, bus_req_valid never asserted.
- LHU, addr 0x2, rsp_data 0xF00D1234 -> resp_rdata 0x0000F00D. Back-to-back request in the next cycle accepted from IDLE.
- TIMEOUT=8, no bus_rsp_valid -> resp_valid with resp_err=1 exactly 8 cycles after entering DATA. Separately, bus_rsp_err=1 -> resp_err=1, resp_rdata 0.
